// File: rtl/interp_fir_serial.sv
// rtl/interp_fir_serial.sv - 8-tap half-band interpolation FIR, serial MAC, one tap per clock
// Optional macro INTERP_FIR_SAT_EN: saturate the rounded output instead of wrapping it.
module interp_fir_serial #(
  parameter int DW   = 24,
  parameter int ACCW = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic signed [DW-1:0] in,
  output logic signed [DW-1:0] out,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 overrun
);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  localparam logic signed [ACCW-1:0] HALF_LSB = ACCW'(8);

  state_t                 state, state_nx;
  logic signed [DW-1:0]   x [8];
  logic signed [ACCW-1:0] acc;
  logic [2:0]             k;
  logic signed [5:0]      coef;
  logic signed [DW+5:0]   prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] rnd;
  logic signed [ACCW-1:0] r;
  logic signed [DW-1:0]   res;
  logic                   accept;

  always_comb begin
    coef = 6'sd0;
    case (k)
      3'd0:    coef = -6'sd1;
      3'd2:    coef = 6'sd9;
      3'd3:    coef = 6'sd16;
      3'd4:    coef = 6'sd9;
      3'd6:    coef = -6'sd1;
      default: coef = 6'sd0;
    endcase
  end

  assign prod     = coef * x[k];
  assign prod_ext = {{(ACCW-DW-6){prod[DW+5]}}, prod};
  assign rnd      = acc + HALF_LSB;
  assign r        = rnd >>> 4;

`ifdef INTERP_FIR_SAT_EN
  // In range when every bit above the output sign bit matches it.
  always_comb begin
    res = r[DW-1:0];
    if (!((&r[ACCW-1:DW-1]) || !(|r[ACCW-1:DW-1])))
      res = r[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  end
`else
  always_comb begin
    res = DW'(r);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: if (enable) begin
        accept   = 1'b1;
        state_nx = MAC;
      end
      MAC:  if (k == 3'd7) state_nx = OUT;
      OUT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) x[i] <= '0;
      acc       <= '0;
      k         <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        for (int i = 7; i > 0; i--) x[i] <= x[i-1];
        x[0] <= in;
        acc  <= '0;
        k    <= '0;
      end
      if (state == MAC) begin
        acc <= acc + prod_ext;
        k   <= k + 3'd1;
      end
      if (state == OUT) begin
        out       <= res;
        out_valid <= 1'b1;
      end
      // Strobes landing in MAC or OUT are dropped, only flagged.
      if (enable && state != IDLE) overrun <= 1'b1;
    end
  end

endmodule

// File: doc/interp_fir_serial.md
Name: interp_fir_serial

Overview:
- Interpolation filter stage directly downstream of the 2x zero-stuffing PCM stage.
- Takes the zero-stuffed 24-bit stream, one sample per `enable` strobe, and low-pass filters it with a fixed 8-tap 4-point Lagrange half-band kernel.
- Uses one serial multiply-accumulate (MAC), one tap per clock; the smoothed output feeds the delta-sigma modulator.
- Shares `clk`, `rst_n` and the `enable` sample strobe with the upstream stage.

Parameters:
- DW, 24, signed data width of `in` and `out`.
- ACCW, 32, signed accumulator width; must be >= DW+7.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  sample strobe; `in` is valid when high.
- in  input  DW  signed two's-complement zero-stuffed sample from the upstream stage.
- out  output  DW  signed filtered sample, registered, held between updates.
- out_valid  output  1  one-cycle pulse when `out` updates.
- busy  output  1  high whenever state != IDLE.
- overrun  output  1  sticky flag: a strobe arrived while busy; cleared only by reset.

Behaviour:
- Reset (asynchronous, active-low, fixed):
  - `out`=0, `out_valid`=0, `overrun`=0, `busy`=0.
  - Delay line x0..x7 = 0, accumulator = 0, tap index = 0, state = IDLE.
- Coefficient ROM, fixed, index k = 0..7: h = {-1, 0, 9, 16, 9, 0, -1, 0}. Width 6 bits signed.
  - Even taps sum to 16; odd taps sum to 16. Each output phase therefore has unity DC gain after the >>4.
- Accepting a sample: edge E0 with state IDLE and `enable`=1:
  - Delay line shifts: x7<=x6 ... x1<=x0, x0<=in.
  - acc<=0, k<=0, state<=MAC.
- MAC state, edges E1..E8: acc<=acc + h[k]*x[k], using the post-shift delay line; then k<=k+1.
  - At E8 (k=7): state<=OUT.
- OUT state, edge E9:
  - r = (acc + 8) >>> 4, arithmetic shift, i.e. round half toward +inf.
  - out<=sat(r); out_valid<=1; state<=IDLE.
- `out_valid` is high for exactly the cycle after E9 and cleared at the next edge.
- Latency: 9 clocks from the accepting edge to `out` update. Minimum strobe spacing is 10 clocks; strobe at E9 is dropped, strobe at E10 is accepted.
- Strobe while busy (MAC or OUT, including E9):
  - Sample dropped; delay line unchanged.
  - Current computation continues unaffected.
  - `overrun`<=1 (sticky).
- Simultaneous `out_valid` pulse and an accepted strobe cannot occur; spacing rules exclude it.
- Saturation: r > 2^(DW-1)-1 gives 0x7FFFFF; r < -2^(DW-1) gives 0x800000 (DW=24).
- Accumulator never overflows for ACCW >= DW+7, since sum |h| = 36.
- Reset mid-operation: immediate return to reset state. No `out_valid` is emitted for the aborted sample, and the delay line is cleared.
- Zero samples from the stuffing stage are ordinary samples; no special casing.

Optional Feature:
- INTERP_FIR_SAT_EN
  - Defined: saturating output as in Behaviour.
  - Undefined: no clamp; `out` = r[DW-1:0] (two's-complement wrap). Saves comparators.

Test Plan:
- Reset: hold rst_n=0 with `enable` toggling -> `out`=0, `out_valid`=0, `busy`=0, `overrun`=0 throughout; no state change.
- Impulse: strobes every 10 clocks with in = 0x000100, then seven strobes of 0.
  - -> 8 outputs 0xFFFFF0, 0, 0x000090, 0x000100, 0x000090, 0, 0xFFFFF0, 0.
  - Each `out_valid` occurs 9 clocks after its accepting edge.
- DC after zero-stuffing: alternate in = 0x100000, 0 for 20 strobes -> from the 8th output onward every `out` = 0x100000.
- Saturation: strobes 0x800000, 0, 0x7FFFFF, 0x7FFFFF, 0x7FFFFF, 0, 0x800000.
  - Last output is 0x7FFFFF with INTERP_FIR_SAT_EN.
  - Last output is 0x1FFFFE without INTERP_FIR_SAT_EN.
- Overrun: strobe at E0 and again at E3, then strobe at E9 and at E10.
  - -> E3 and E9 samples dropped; `overrun`=1 from E3 onward.
  - Exactly one `out_valid` for E0 and one for E10.
- Reset mid-MAC: after a 0x000100 strobe, pulse rst_n low at E4.
  - -> no `out_valid`.
  - Next strobe of 0 yields `out`=0; delay line was cleared.
